// File: rtl/sha256_pkg.sv
// Shared constants, round functions and FSM encoding for the SHA-256 core.
package sha256_pkg;

  // Round constants, indexed by round number.
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value; H0 (a) sits in the low word.
  localparam logic [255:0] SHA256_IV =
    256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;

  // Upper half of the second-pass block: 0x80 terminator in W8, bit length 256 in W15.
  localparam logic [255:0] SHA256_PAD2 =
    256'h0000010000000000000000000000000000000000000000000000000080000000;

  // FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ROUND = 2'd1;
  localparam state_t S_FINAL = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise modulo-2^32 addition of two packed 8-word states.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: (a..h, W, K) -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {h, g, f, e, d, c, b, a} = state_i;
  assign t1 = h + ep1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = ep0(a) + maj(a, b, c);
  assign state_o = {g, f, e, d + t1, c, b, a, t1 + t2};

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression engine with optional second (double) pass.
module sha256_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 4,
  parameter int TAG_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_block,
  input  logic [255:0]     in_state,
  input  logic             in_dbl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_digest,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [5:0] CNT_STEP = 6'(ROUNDS_PER_CYCLE);

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic               dbl_q, dbl_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [255:0]       digest_q, digest_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [511:0]       w_q, w_d;
  logic [255:0]       work_q, work_d;
  logic [255:0]       hash_q, hash_d;

  logic [255:0]       st_chain [ROUNDS_PER_CYCLE+1];
  logic [511:0]       w_chain  [ROUNDS_PER_CYCLE+1];
  logic [255:0]       digest_sum;
  logic               last_step;

  assign st_chain[0] = work_q;
  assign w_chain[0]  = w_q;

  // Chain R rounds per clock; each round consumes the W head and extends the schedule by one word.
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    sha256_round u_round (
      .state_i (st_chain[i]),
      .w_i     (w_chain[i][31:0]),
      .k_i     (K[cnt_q + 6'(i)]),
      .state_o (st_chain[i+1])
    );
    assign w_chain[i+1] = {sig1(w_chain[i][479:448]) + w_chain[i][319:288] +
                           sig0(w_chain[i][63:32]) + w_chain[i][31:0],
                           w_chain[i][511:32]};
  end

  assign digest_sum = add_words(hash_q, work_q);
  assign last_step  = ({1'b0, cnt_q} + {1'b0, CNT_STEP}) == 7'd64;

  // Next-state, datapath and output-register decode.
  always_comb begin
    // NOTE: every _d starts at its hold value so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    dbl_d     = dbl_q;
    tag_d     = tag_q;
    digest_d  = digest_q;
    out_tag_d = out_tag_q;
    w_d       = w_q;
    work_d    = work_q;
    hash_d    = hash_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          w_d     = in_block;
          work_d  = in_state;
          hash_d  = in_state;
          dbl_d   = in_dbl;
          tag_d   = in_tag;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        work_d = st_chain[ROUNDS_PER_CYCLE];
        w_d    = w_chain[ROUNDS_PER_CYCLE];
        cnt_d  = cnt_q + CNT_STEP;
        if (last_step) state_d = S_FINAL;
      end
      S_FINAL: begin
        if (dbl_q && !pass_q) begin
          w_d     = {SHA256_PAD2, digest_sum};
          work_d  = SHA256_IV;
          hash_d  = SHA256_IV;
          pass_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_ROUND;
        end else begin
          digest_d  = digest_sum;
          out_tag_d = tag_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Control and result registers, cleared by reset so an aborted request leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      dbl_q       <= 1'b0;
      tag_q       <= '0;
      digest_q    <= '0;
      out_tag_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      dbl_q       <= dbl_d;
      tag_q       <= tag_d;
      digest_q    <= digest_d;
      out_tag_q   <= out_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Working datapath registers.
  // NOTE: no reset here; these are always loaded on accept before anything reads them.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    work_q <= work_d;
    hash_q <= hash_d;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_digest = digest_q;
  assign out_tag    = out_tag_q;

endmodule
